// File: rtl/mul_unit_pipe.sv
// Fully pipelined unsigned multiply unit: tagged results go to the CDB after LATENCY cycles and wait there for a grant.
// Optional squash port: define MUL_FLUSH_EN.
module mul_unit_pipe #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TAG_W   = 3,
  parameter int unsigned LATENCY = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic [DATA_W-1:0] issue_op_a,
  input  logic [DATA_W-1:0] issue_op_b,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              busy,
  output logic [4:0]        inflight_cnt
`ifdef MUL_FLUSH_EN
  ,
  input  logic              flush
`endif
);

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned LAST   = LATENCY - 1;

  logic [LATENCY-1:0] vld_q;
  logic [TAG_W-1:0]   tag_q  [LATENCY];
  logic [DATA_W-1:0]  prod_q [LATENCY];
  logic [LATENCY-1:0] adv_c;
  logic [DATA_W-1:0]  prod_c;
  logic [CNT_W-1:0]   cnt_next_c;
  logic               accept_c;
  logic               retire_c;
  logic               flush_c;

`ifdef MUL_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  // Low half of the full product; upper bits are dropped by design.
  assign prod_c = DATA_W'(PROD_W'(issue_op_a) * PROD_W'(issue_op_b));

  // A stage moves when its successor is empty or itself moving; the output stage moves on grant.
  always_comb begin
    adv_c       = '0;
    adv_c[LAST] = vld_q[LAST] && cdb_grant;
    for (int i = int'(LATENCY) - 2; i >= 0; i--) begin
      adv_c[i] = vld_q[i] && (!vld_q[i+1] || adv_c[i+1]);
    end
  end

  assign issue_ready = !vld_q[0] || adv_c[0];
  assign accept_c    = issue_valid && issue_ready && !flush_c;
  assign retire_c    = adv_c[LAST] && !flush_c;

  always_comb begin
    cnt_next_c = inflight_cnt;
    unique case ({accept_c, retire_c})
      2'b10:   cnt_next_c = inflight_cnt + CNT_W'(1);
      2'b01:   cnt_next_c = inflight_cnt - CNT_W'(1);
      default: cnt_next_c = inflight_cnt;
    endcase
  end

  assign cdb_req  = vld_q[LAST];
  assign cdb_tag  = tag_q[LAST];
  assign cdb_data = prod_q[LAST];

  // Output-stage payload is zeroed whenever it empties so the CDB sees 0 while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q        <= '0;
      inflight_cnt <= '0;
      busy         <= 1'b0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        tag_q[i]  <= '0;
        prod_q[i] <= '0;
      end
    end else if (flush_c) begin
      vld_q        <= '0;
      tag_q[LAST]  <= '0;
      prod_q[LAST] <= '0;
      inflight_cnt <= '0;
      busy         <= 1'b0;
    end else begin
      if (accept_c) begin
        vld_q[0]  <= 1'b1;
        tag_q[0]  <= issue_tag;
        prod_q[0] <= prod_c;
      end else if (adv_c[0]) begin
        vld_q[0] <= 1'b0;
      end
      for (int unsigned i = 1; i < LATENCY; i++) begin
        if (adv_c[i-1]) begin
          vld_q[i]  <= 1'b1;
          tag_q[i]  <= tag_q[i-1];
          prod_q[i] <= prod_q[i-1];
        end else if (adv_c[i]) begin
          vld_q[i] <= 1'b0;
          if (i == LAST) begin
            tag_q[i]  <= '0;
            prod_q[i] <= '0;
          end
        end
      end
      inflight_cnt <= cnt_next_c;
      busy         <= (cnt_next_c != '0);
    end
  end

endmodule

// File: tb/tb_mul_unit_pipe.sv
// Self-checking bench for mul_unit_pipe: queue-based reference model of issue order and truncated products.
module tb_mul_unit_pipe;

  localparam int unsigned DW  = 8;
  localparam int unsigned TW  = 3;
  localparam int unsigned LAT = 6;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          issue_valid;
  logic          issue_ready;
  logic [TW-1:0] issue_tag;
  logic [DW-1:0] issue_op_a;
  logic [DW-1:0] issue_op_b;
  logic          cdb_req;
  logic          cdb_grant;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
  logic          busy;
  logic [4:0]    inflight_cnt;
`ifdef MUL_FLUSH_EN
  logic          flush;
`endif

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  logic          obs_acc, obs_ret, obs_req, obs_rdy;
  logic [TW-1:0] obs_tag;
  logic [DW-1:0] obs_data;

  mul_unit_pipe #(.DATA_W(DW), .TAG_W(TW), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_tag    (issue_tag),
    .issue_op_a   (issue_op_a),
    .issue_op_b   (issue_op_b),
    .cdb_req      (cdb_req),
    .cdb_grant    (cdb_grant),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .busy         (busy),
    .inflight_cnt (inflight_cnt)
`ifdef MUL_FLUSH_EN
    ,
    .flush        (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle starting at a falling edge: drive, observe pre-edge, update model on accept.
  task automatic drive_cycle(input logic v, input logic [TW-1:0] t, input logic [DW-1:0] a,
                             input logic [DW-1:0] b, input logic g, input logic f);
    exp_t e;
    issue_valid = v;
    issue_tag   = t;
    issue_op_a  = a;
    issue_op_b  = b;
    cdb_grant   = g;
`ifdef MUL_FLUSH_EN
    flush = f;
`endif
    #1;
    obs_rdy  = issue_ready;
    obs_acc  = v && issue_ready && !f;
    obs_req  = cdb_req;
    obs_ret  = cdb_req && g && !f;
    obs_tag  = cdb_tag;
    obs_data = cdb_data;
    @(posedge clk);
    if (obs_acc) begin
      e.tag  = t;
      e.data = DW'((int'(a) * int'(b)) % 256);
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; issue_valid = 1'b0; issue_tag = '0; issue_op_a = '0; issue_op_b = '0;
    cdb_grant = 1'b0;
`ifdef MUL_FLUSH_EN
    flush = 1'b0;
`endif
    #1;
    n_chk++; if (cdb_req !== 1'b0 || cdb_tag !== '0 || cdb_data !== '0)
      $display("FAIL reset_cdb: req=%b tag=%0d data=%0h expected 0/0/0", cdb_req, cdb_tag, cdb_data);
    else n_pass++;
    n_chk++; if (busy !== 1'b0 || inflight_cnt !== 5'd0)
      $display("FAIL reset_cnt: busy=%b cnt=%0d expected 0/0", busy, inflight_cnt);
    else n_pass++;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++; if (issue_ready !== 1'b1)
      $display("FAIL reset_ready: issue_ready=%b expected 1", issue_ready);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_single();
    int k_hit = 0;
    drive_cycle(1'b1, 3'd5, 8'd7, 8'd9, 1'b1, 1'b0);
    n_chk++; if (obs_acc !== 1'b1 || inflight_cnt !== 5'd1)
      $display("FAIL single_accept: acc=%b cnt=%0d expected 1/1", obs_acc, inflight_cnt);
    else n_pass++;
    for (int k = 1; k <= 20 && k_hit == 0; k++) begin
      drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
      if (obs_ret) begin
        k_hit = k;
        void'(q.pop_front());
        n_chk++; if (obs_tag !== 3'd5 || obs_data !== 8'h3F)
          $display("FAIL single_result: tag=%0d data=%0h expected 5/3f", obs_tag, obs_data);
        else n_pass++;
      end
    end
    n_chk++; if (k_hit != int'(LAT))
      $display("FAIL single_latency: req after %0d cycles expected %0d", k_hit, LAT);
    else n_pass++;
    n_chk++; if (inflight_cnt !== 5'd0 || busy !== 1'b0)
      $display("FAIL single_drain: cnt=%0d busy=%b expected 0/0", inflight_cnt, busy);
    else n_pass++;
    q.delete();
  endtask

  task automatic test_overflow();
    logic [DW-1:0] lit [2];
    int n = 0;
    exp_t e;
    lit[0] = 8'h00; lit[1] = 8'h01;
    drive_cycle(1'b1, 3'd1, 8'h10, 8'h10, 1'b1, 1'b0);
    drive_cycle(1'b1, 3'd2, 8'hFF, 8'hFF, 1'b1, 1'b0);
    for (int c = 0; c < 20 && n < 2; c++) begin
      drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
      if (obs_ret) begin
        e = q.pop_front();
        n_chk++; if (obs_data !== lit[n] || obs_data !== e.data || obs_tag !== e.tag)
          $display("FAIL overflow_%0d: tag=%0d data=%0h expected %0d/%0h", n, obs_tag, obs_data, e.tag, lit[n]);
        else n_pass++;
        n++;
      end
    end
    n_chk++; if (n != 2) $display("FAIL overflow_count: got %0d results expected 2", n);
    else n_pass++;
    q.delete();
  endtask

  task automatic test_back_to_back();
    int n = 0, first = -1, cyc = 0;
    bit consec = 1'b1;
    for (int i = 0; i < 8 + 20 && n < 8; i++) begin
      if (i < 8) drive_cycle(1'b1, TW'(i), DW'(i), 8'd3, 1'b1, 1'b0);
      else       drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
      if (i < 8) begin
        n_chk++; if (obs_acc !== 1'b1) $display("FAIL b2b_accept_%0d: acc=%b expected 1", i, obs_acc);
        else n_pass++;
      end
      if (obs_ret) begin
        if (first < 0) first = cyc;
        if (cyc != first + n) consec = 1'b0;
        void'(q.pop_front());
        n_chk++; if (obs_tag !== TW'(n) || obs_data !== DW'(3 * n))
          $display("FAIL b2b_result_%0d: tag=%0d data=%0d expected %0d/%0d", n, obs_tag, obs_data, n, 3 * n);
        else n_pass++;
        n++;
      end
      cyc++;
    end
    n_chk++; if (n != 8 || !consec || first != int'(LAT))
      $display("FAIL b2b_stream: count=%0d consecutive=%b first=%0d expected 8/1/%0d", n, consec, first, LAT);
    else n_pass++;
    q.delete();
  endtask

  task automatic test_stall();
    int n_acc = 0;
    bit have = 1'b0;
    logic [TW-1:0] st_tag;
    logic [DW-1:0] st_data;
    exp_t e;
    for (int c = 0; c < 10; c++) begin
      drive_cycle(1'b1, TW'($urandom), DW'($urandom), DW'($urandom), 1'b0, 1'b0);
      if (obs_acc) n_acc++;
      if (obs_req) begin
        if (!have) begin
          have = 1'b1; st_tag = obs_tag; st_data = obs_data;
        end else begin
          n_chk++; if (obs_tag !== st_tag || obs_data !== st_data)
            $display("FAIL stall_stable: tag=%0d data=%0h expected %0d/%0h", obs_tag, obs_data, st_tag, st_data);
          else n_pass++;
        end
      end
    end
    n_chk++; if (n_acc != int'(LAT) || inflight_cnt !== 5'(LAT) || issue_ready !== 1'b0)
      $display("FAIL stall_full: accepts=%0d cnt=%0d ready=%b expected %0d/%0d/0", n_acc, inflight_cnt, issue_ready, LAT, LAT);
    else n_pass++;
    drive_cycle(1'b1, TW'($urandom), DW'($urandom), DW'($urandom), 1'b1, 1'b0);
    n_chk++; if (obs_rdy !== 1'b1 || obs_ret !== 1'b1 || obs_acc !== 1'b1)
      $display("FAIL stall_release: ready=%b ret=%b acc=%b expected 1/1/1", obs_rdy, obs_ret, obs_acc);
    else n_pass++;
    if (obs_ret) begin
      e = q.pop_front();
      n_chk++; if (obs_tag !== e.tag || obs_data !== e.data)
        $display("FAIL stall_first: tag=%0d data=%0h expected %0d/%0h", obs_tag, obs_data, e.tag, e.data);
      else n_pass++;
    end
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
      n_chk++; if (obs_ret !== 1'b1) $display("FAIL stall_drain_rate: ret=%b expected 1", obs_ret);
      else n_pass++;
      if (obs_ret) begin
        e = q.pop_front();
        n_chk++; if (obs_tag !== e.tag || obs_data !== e.data)
          $display("FAIL stall_drain: tag=%0d data=%0h expected %0d/%0h", obs_tag, obs_data, e.tag, e.data);
        else n_pass++;
      end
    end
    n_chk++; if (inflight_cnt !== 5'd0 || q.size() != 0)
      $display("FAIL stall_empty: cnt=%0d model=%0d expected 0/0", inflight_cnt, q.size());
    else n_pass++;
    q.delete();
  endtask

  task automatic test_async_reset();
    int n_ret = 0, k_hit = 0;
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, TW'(i + 1), DW'($urandom), DW'($urandom), 1'b1, 1'b0);
    n_chk++; if (inflight_cnt !== 5'd4) $display("FAIL arst_pre: cnt=%0d expected 4", inflight_cnt);
    else n_pass++;
    issue_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (inflight_cnt !== 5'd0 || busy !== 1'b0 || cdb_req !== 1'b0 || cdb_tag !== '0 || cdb_data !== '0)
      $display("FAIL arst_immediate: cnt=%0d busy=%b req=%b tag=%0d data=%0h expected all 0",
               inflight_cnt, busy, cdb_req, cdb_tag, cdb_data);
    else n_pass++;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
      if (obs_req) n_ret++;
    end
    n_chk++; if (n_ret != 0) $display("FAIL arst_ghost: %0d results after reset expected 0", n_ret);
    else n_pass++;
    drive_cycle(1'b1, 3'd6, 8'd12, 8'd11, 1'b1, 1'b0);
    for (int k = 1; k <= 20 && k_hit == 0; k++) begin
      drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
      if (obs_ret) begin
        k_hit = k;
        void'(q.pop_front());
        n_chk++; if (obs_tag !== 3'd6 || obs_data !== 8'd132)
          $display("FAIL arst_newop: tag=%0d data=%0d expected 6/132", obs_tag, obs_data);
        else n_pass++;
      end
    end
    n_chk++; if (k_hit != int'(LAT)) $display("FAIL arst_latency: %0d cycles expected %0d", k_hit, LAT);
    else n_pass++;
    q.delete();
  endtask

`ifdef MUL_FLUSH_EN
  task automatic test_flush();
    int n_ret = 0;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, TW'(i + 2), DW'($urandom), DW'($urandom), 1'b0, 1'b0);
    for (int c = 0; c < 10 && !cdb_req; c++) drive_cycle(1'b0, '0, '0, '0, 1'b0, 1'b0);
    drive_cycle(1'b1, 3'd7, DW'($urandom), DW'($urandom), 1'b1, 1'b1);
    n_chk++; if (obs_req !== 1'b1) $display("FAIL flush_setup: req=%b expected 1 before flush", obs_req);
    else n_pass++;
    n_chk++; if (cdb_req !== 1'b0 || inflight_cnt !== 5'd0 || busy !== 1'b0)
      $display("FAIL flush_clear: req=%b cnt=%0d busy=%b expected 0/0/0", cdb_req, inflight_cnt, busy);
    else n_pass++;
    q.delete();
    for (int c = 0; c < 12; c++) begin
      drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
      if (obs_req) n_ret++;
    end
    n_chk++; if (n_ret != 0) $display("FAIL flush_ghost: %0d results after flush expected 0", n_ret);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    exp_t e;
    bit v, g;
    for (int c = 0; c < 300 + 40; c++) begin
      v = (c < 300) && ($urandom % 4 != 0);
      g = (c >= 300) || ($urandom % 3 != 0);
      drive_cycle(v, TW'($urandom), DW'($urandom), DW'($urandom), g, 1'b0);
      if (obs_ret) begin
        n_chk++;
        if (q.size() == 0) $display("FAIL rand_extra: unexpected result tag=%0d data=%0h", obs_tag, obs_data);
        else begin
          e = q.pop_front();
          if (obs_tag !== e.tag || obs_data !== e.data)
            $display("FAIL rand_result: tag=%0d data=%0h expected %0d/%0h", obs_tag, obs_data, e.tag, e.data);
          else n_pass++;
        end
      end else if (!obs_req) begin
        n_chk++; if (obs_tag !== '0 || obs_data !== '0)
          $display("FAIL rand_idle_zero: tag=%0d data=%0h expected 0/0", obs_tag, obs_data);
        else n_pass++;
      end
      n_chk++; if (inflight_cnt !== 5'(q.size()) || busy !== (q.size() != 0) || inflight_cnt > 5'(LAT))
        $display("FAIL rand_count: cnt=%0d busy=%b expected %0d/%b", inflight_cnt, busy, q.size(), q.size() != 0);
      else n_pass++;
    end
    n_chk++; if (q.size() != 0) $display("FAIL rand_drain: %0d results missing expected 0", q.size());
    else n_pass++;
    q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_stall();
    test_async_reset();
`ifdef MUL_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mul_unit_pipe.md
Name: mul_unit_pipe

Overview:
- Parametrised, fully pipelined integer multiply functional unit for the Tomasulo core.
- Accepts one tagged operand pair per cycle from the multiply reservation station.
- Presents each result with its reservation-station tag to the common data bus (CDB) after a fixed latency.
- Holds each result until the CDB arbiter grants it, stalling the pipeline when no grant arrives.

Parameters:
- DATA_W, 8, operand and result width in bits.
- TAG_W, 3, reservation-station tag width.
- LATENCY, 6, cycles from issue acceptance to result valid when there is no CDB stall; legal range 2..16.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  reservation station presents an operation.
- issue_ready  out  1  unit can accept an operation this cycle.
- issue_tag  in  TAG_W  tag of the issuing reservation-station entry.
- issue_op_a  in  DATA_W  operand A (unsigned).
- issue_op_b  in  DATA_W  operand B (unsigned).
- cdb_req  out  1  result valid; requesting the CDB.
- cdb_grant  in  1  arbiter grants the CDB this cycle.
- cdb_tag  out  TAG_W  tag of the presented result.
- cdb_data  out  DATA_W  product, low DATA_W bits.
- busy  out  1  at least one operation is in flight or held.
- inflight_cnt  out  5  number of valid pipeline stages, including the output stage.
- flush  in  1  squash all in-flight operations; present only with MUL_FLUSH_EN.

Behaviour:
- Reset (asynchronous, rst_n low):
  - all stage valid bits clear;
  - cdb_req=0, cdb_tag=0, cdb_data=0, busy=0, inflight_cnt=0;
  - issue_ready=1 once rst_n is high.
- Reset mid-operation discards every in-flight operation. No result is emitted for it.
- Pipeline structure:
  - LATENCY register stages; each stage holds {valid, tag, a, b} or a partial product.
  - The final stage is the output stage; it drives cdb_req, cdb_tag and cdb_data.
  - The product is computed combinationally in stage 1 and carried forward. Internal split is free, provided latency is exact.
- Issue handshake: an operation is accepted on a rising edge where issue_valid && issue_ready.
- Unstalled latency: an operation accepted at edge N gives cdb_req=1 after edge N+LATENCY-1, i.e. LATENCY cycles of occupancy.
- Output and stall:
  - Output stage valid and cdb_grant=0 means stall. Every stage whose successor cannot advance holds its contents. Bubbles collapse: a stage advances if its successor is empty or advancing.
  - issue_ready = !stage1_valid || stage1_advances.
  - Throughput with continuous grants is 1 result per cycle.
- Output values:
  - cdb_tag and cdb_data are stable while cdb_req=1 and cdb_grant=0.
  - When cdb_req=0 they are driven to 0, never z.
  - A result leaves on the edge where cdb_req && cdb_grant. A following result may appear the next cycle.
  - cdb_grant while cdb_req=0 is ignored.
- Arithmetic: unsigned DATA_W x DATA_W. The upper DATA_W bits are discarded. For example, 0x10*0x10 with DATA_W=8 gives 0x00.
- Counter:
  - inflight_cnt is +1 on accept, -1 on grant-retire, unchanged when both happen in the same cycle.
  - Maximum value is LATENCY.
  - busy = (inflight_cnt != 0).
- Ordering: results retire in strict issue order. Tags are passed through unmodified; duplicate tags are allowed.
- Simultaneous events: accept and retire in the same cycle with a full pipe is legal. Every stage advances, with no bubble inserted.

Optional Feature:
- Macro: MUL_FLUSH_EN.
- Defined:
  - flush port exists.
  - flush=1 at an edge clears every valid bit, including the output stage. A pending cdb_req drops the next cycle.
  - inflight_cnt goes to 0.
  - An issue in the same cycle as flush is discarded.
  - flush has priority over cdb_grant; a same-edge grant does not count as retired.
- Undefined: no flush port; the pipeline is only cleared by rst_n.

Test Plan:
- Single op, grant held 1: tag=5, a=7, b=9, LATENCY=6 -> cdb_req rises exactly 6 cycles after accept with tag=5, data=63 (0x3F); inflight_cnt 1 then 0.
- Overflow truncation: a=0x10, b=0x10 -> data=0x00; a=0xFF, b=0xFF -> data=0x01.
- Back-to-back: issue 8 ops on consecutive cycles, tags 0..7, a=i, b=3, grant always 1 -> 8 consecutive cdb_req cycles, data 0,3,...,21, tags in order.
- Stall:
  - Stimulus: grant=0 for 10 cycles with continuous issue.
  - Required: issue_ready drops after 6 accepts; cdb_tag/cdb_data stable; inflight_cnt=6.
  - On grant=1: one retire per cycle, issue_ready returns the same cycle the first result retires.
- Async reset mid-stream: assert rst_n=0 between edges with 4 ops in flight -> outputs 0 immediately; no results after release; first new op completes in 6 cycles.
- MUL_FLUSH_EN: flush with 3 ops in flight plus a simultaneous issue and grant -> no cdb_req next cycle, inflight_cnt=0, no later results from squashed tags.
